// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU data port (A) and a host port (B),
// and decodes 0xFFFFFE (STDOUT) / 0xFFFFFF (HALT). Optional macro ARB_STARVE_GUARD_EN adds a B wait guard.
module dmem_arbiter #(
    parameter int AW       = 24,
    parameter int DW       = 32,
    parameter int RAM_AW   = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clk_en,

    input  logic              i_a_req,
    input  logic              i_a_wr,
    input  logic [AW-1:0]     i_a_addr,
    input  logic [DW-1:0]     i_a_wdata,
    output logic              o_a_gnt,
    output logic [DW-1:0]     o_a_rdata,
    output logic              o_a_rvld,

    input  logic              i_b_req,
    input  logic              i_b_wr,
    input  logic [AW-1:0]     i_b_addr,
    input  logic [DW-1:0]     i_b_wdata,
    input  logic              i_b_lock,
    output logic              o_b_gnt,
    output logic [DW-1:0]     o_b_rdata,
    output logic              o_b_rvld,

    output logic              o_ram_en,
    output logic              o_ram_wr,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic [DW-1:0]     o_ram_wdata,
    input  logic [DW-1:0]     i_ram_rdata,

    output logic              o_stdout_vld,
    output logic [DW-1:0]     o_stdout_data,
    output logic              o_halt,

    output logic [1:0]        o_dbg_state
);

    localparam logic [1:0]    ST_RUN  = 2'd0;
    localparam logic [1:0]    ST_LOCK = 2'd1;
    localparam logic [1:0]    ST_HALT = 2'd2;
    localparam logic [AW-2:0] IO_HI   = '1;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          w_en;
    logic          w_starve;
    logic          w_a_gnt;
    logic          w_b_gnt;
    logic          w_acc;
    logic          w_wr;
    logic          w_io;
    logic          w_io_wr_stdout;
    logic          w_io_wr_halt;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    logic          r_a_rvld;
    logic          r_b_rvld;
    logic          r_tag_io;
    logic [DW-1:0] r_tag_iodata;
    logic          r_stdout_vld;
    logic [DW-1:0] r_stdout_data;
    logic          r_halt;

    assign w_en = i_clk_en & ~i_rst;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [CW-1:0] r_wait_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait_cnt <= '0;
        end else if (i_clk_en) begin
            if (!i_b_req || w_b_gnt) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != CW'(MAX_WAIT)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    assign w_starve = (r_wait_cnt == CW'(MAX_WAIT));
`else
    // Guard compiled out: B never overrides A in RUN.
    assign w_starve = (MAX_WAIT < 0);
`endif

    // Handshake: a port's request is accepted on the rising edge where its req, its gnt and
    // i_clk_en are all high; gnt is offered combinationally and may stay low while req is held.
    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (w_en) begin
            case (r_state)
                ST_RUN: begin
                    if (i_b_req && (w_starve || !i_a_req)) begin
                        w_b_gnt = 1'b1;
                    end else begin
                        w_a_gnt = i_a_req;
                    end
                end
                default: w_b_gnt = i_b_req;
            endcase
        end
    end

    assign w_acc   = w_a_gnt | w_b_gnt;
    assign w_addr  = w_b_gnt ? i_b_addr  : i_a_addr;
    assign w_wr    = w_b_gnt ? i_b_wr    : i_a_wr;
    assign w_wdata = w_b_gnt ? i_b_wdata : i_a_wdata;
    assign w_io    = (w_addr[AW-1:1] == IO_HI);

    assign w_io_wr_stdout = w_acc & w_wr & w_io & ~w_addr[0];
    assign w_io_wr_halt   = w_acc & w_wr & w_io &  w_addr[0];

    assign o_ram_en    = w_acc & ~w_io;
    assign o_ram_wr    = o_ram_en & w_wr;
    assign o_ram_addr  = o_ram_en ? w_addr[RAM_AW-1:0] : '0;
    assign o_ram_wdata = o_ram_wr ? w_wdata : '0;

    // A HALT write wins over any lock transition taken in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (w_io_wr_halt) begin
            w_state_nxt = ST_HALT;
        end else begin
            case (r_state)
                ST_RUN:  if (w_b_gnt && i_b_lock) w_state_nxt = ST_LOCK;
                ST_LOCK: if ((w_b_gnt && !i_b_lock) || !i_b_req) w_state_nxt = ST_RUN;
                ST_HALT: w_state_nxt = ST_HALT;
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
        end else if (i_clk_en) begin
            r_state <= w_state_nxt;
        end
    end

    // Read tag: owner bits plus whether the data comes from the RAM or from the I/O decode.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_rvld     <= 1'b0;
            r_b_rvld     <= 1'b0;
            r_tag_io     <= 1'b0;
            r_tag_iodata <= '0;
        end else if (i_clk_en) begin
            r_a_rvld     <= w_a_gnt & ~i_a_wr;
            r_b_rvld     <= w_b_gnt & ~i_b_wr;
            r_tag_io     <= w_io;
            r_tag_iodata <= w_addr[0] ? {{(DW-1){1'b0}}, r_halt} : '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stdout_vld  <= 1'b0;
            r_stdout_data <= '0;
            r_halt        <= 1'b0;
        end else if (i_clk_en) begin
            r_stdout_vld <= w_io_wr_stdout;
            if (w_io_wr_stdout) begin
                r_stdout_data <= w_wdata;
            end
            if (w_io_wr_halt) begin
                r_halt <= 1'b1;
            end
        end
    end

    assign o_a_gnt       = w_a_gnt;
    assign o_b_gnt       = w_b_gnt;
    assign o_a_rvld      = r_a_rvld;
    assign o_b_rvld      = r_b_rvld;
    assign o_a_rdata     = r_a_rvld ? (r_tag_io ? r_tag_iodata : i_ram_rdata) : '0;
    assign o_b_rdata     = r_b_rvld ? (r_tag_io ? r_tag_iodata : i_ram_rdata) : '0;
    assign o_stdout_vld  = r_stdout_vld;
    assign o_stdout_data = r_stdout_data;
    assign o_halt        = r_halt;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus random traffic against a cycle-level reference model;
// read data is checked through per-port expected queues by a separate monitor.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int AW       = 24;
    localparam int DW       = 32;
    localparam int RAM_AW   = 16;
    localparam int MAX_WAIT = 4;
    localparam logic [AW-1:0] A_STDOUT = 24'hFFFFFE;
    localparam logic [AW-1:0] A_HALT   = 24'hFFFFFF;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              i_rst = 1'b0, i_clk_en = 1'b0;
    logic              i_a_req = 1'b0, i_a_wr = 1'b0;
    logic [AW-1:0]     i_a_addr = '0;
    logic [DW-1:0]     i_a_wdata = '0;
    logic              i_b_req = 1'b0, i_b_wr = 1'b0, i_b_lock = 1'b0;
    logic [AW-1:0]     i_b_addr = '0;
    logic [DW-1:0]     i_b_wdata = '0;
    logic              o_a_gnt, o_a_rvld, o_b_gnt, o_b_rvld;
    logic [DW-1:0]     o_a_rdata, o_b_rdata;
    logic              o_ram_en, o_ram_wr;
    logic [RAM_AW-1:0] o_ram_addr;
    logic [DW-1:0]     o_ram_wdata;
    logic [DW-1:0]     ram_rdata = '0;
    logic              o_stdout_vld, o_halt;
    logic [DW-1:0]     o_stdout_data;
    logic [1:0]        o_dbg_state;

    dmem_arbiter #(.AW(AW), .DW(DW), .RAM_AW(RAM_AW), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_clk_en(i_clk_en),
        .i_a_req(i_a_req), .i_a_wr(i_a_wr), .i_a_addr(i_a_addr), .i_a_wdata(i_a_wdata),
        .o_a_gnt(o_a_gnt), .o_a_rdata(o_a_rdata), .o_a_rvld(o_a_rvld),
        .i_b_req(i_b_req), .i_b_wr(i_b_wr), .i_b_addr(i_b_addr), .i_b_wdata(i_b_wdata),
        .i_b_lock(i_b_lock),
        .o_b_gnt(o_b_gnt), .o_b_rdata(o_b_rdata), .o_b_rvld(o_b_rvld),
        .o_ram_en(o_ram_en), .o_ram_wr(o_ram_wr), .o_ram_addr(o_ram_addr),
        .o_ram_wdata(o_ram_wdata), .i_ram_rdata(ram_rdata),
        .o_stdout_vld(o_stdout_vld), .o_stdout_data(o_stdout_data), .o_halt(o_halt),
        .o_dbg_state(o_dbg_state)
    );

    // Bench-side RAM the DUT drives
    logic [DW-1:0] ram [0:(1<<RAM_AW)-1];
    always @(posedge clk) begin
        if (o_ram_en) begin
            if (o_ram_wr) ram[o_ram_addr] <= o_ram_wdata;
            else          ram_rdata <= ram[o_ram_addr];
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [DW-1:0] ref_mem [0:(1<<RAM_AW)-1];
    bit            m_ok = 1'b0;
    bit            m_halted, m_locked, m_stdout_vld;
    int            m_wait;
    logic [DW-1:0] m_stdout_data;
    logic [DW-1:0] exp_a_q[$];
    logic [DW-1:0] exp_b_q[$];
    int            n_checks = 0;
    int            n_err = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver: one cycle of stimulus + model step ----------------
    task automatic step(input bit rst, input bit en,
                        input bit ar, input bit aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input bit br, input bit bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                        input bit bl);
        bit            a_win, b_win, acc, wr, is_io;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd, rd;
        @(negedge clk);
        i_rst = rst; i_clk_en = en;
        i_a_req = ar; i_a_wr = aw; i_a_addr = aa; i_a_wdata = ad;
        i_b_req = br; i_b_wr = bw; i_b_addr = ba; i_b_wdata = bd; i_b_lock = bl;
        if (rst) begin
            exp_a_q.delete();
            exp_b_q.delete();
        end
        #1;
        if (m_ok) begin
            chk("halt", {31'd0, o_halt}, {31'd0, m_halted});
            chk("stdout_vld", {31'd0, o_stdout_vld}, {31'd0, m_stdout_vld});
            chk("stdout_data", o_stdout_data, m_stdout_data);
        end
        // Who should win this cycle
        a_win = 1'b0; b_win = 1'b0;
        if (en && !rst) begin
            if (m_halted || m_locked)                                  b_win = br;
            else if (br && (!ar || (GUARD && m_wait >= MAX_WAIT)))     b_win = 1'b1;
            else                                                       a_win = ar;
        end
        chk("a_gnt", {31'd0, o_a_gnt}, {31'd0, a_win});
        chk("b_gnt", {31'd0, o_b_gnt}, {31'd0, b_win});
        acc   = a_win || b_win;
        addr  = b_win ? ba : aa;
        wr    = b_win ? bw : aw;
        wd    = b_win ? bd : ad;
        is_io = (addr >= A_STDOUT);
        chk("ram_en", {31'd0, o_ram_en}, {31'd0, acc && !is_io});
        if (acc && !is_io) begin
            chk("ram_addr", DW'(o_ram_addr), DW'(addr[RAM_AW-1:0]));
            chk("ram_wr", {31'd0, o_ram_wr}, {31'd0, wr});
            if (wr) chk("ram_wdata", o_ram_wdata, wd);
        end
        // Effect of the coming edge
        if (rst) begin
            m_ok = 1'b1; m_halted = 1'b0; m_locked = 1'b0; m_stdout_vld = 1'b0;
            m_wait = 0; m_stdout_data = '0;
        end else if (en) begin
            if (acc && !wr) begin
                if (is_io) rd = (addr == A_HALT) ? DW'(m_halted) : '0;
                else       rd = ref_mem[addr[RAM_AW-1:0]];
                if (a_win) exp_a_q.push_back(rd);
                else       exp_b_q.push_back(rd);
            end
            m_stdout_vld = acc && wr && (addr == A_STDOUT);
            if (m_stdout_vld) m_stdout_data = wd;
            if (acc && wr && addr == A_HALT) m_halted = 1'b1;
            if (acc && wr && !is_io) ref_mem[addr[RAM_AW-1:0]] = wd;
            if (m_halted)       m_locked = 1'b0;
            else if (m_locked)  m_locked = !((b_win && !bl) || !br);
            else                m_locked = b_win && bl;
            if (!br || b_win)          m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait++;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 1, 0, 0, '0, '0, 0, 0, '0, '0, 0);
    endtask

    task automatic do_reset();
        step(1, 1, 0, 0, '0, '0, 0, 0, '0, '0, 0);
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        logic [AW-1:0] a;
        int k;
        k = $urandom_range(0, 99);
        if (k < 1) return A_HALT;
        if (k < 8) return A_STDOUT;
        if (k < 20) begin
            a = AW'($urandom());
            a[RAM_AW-1:0] = RAM_AW'($urandom_range(0, 31));
            if (a >= A_STDOUT) a[AW-1] = 1'b0;
            return a;
        end
        return AW'($urandom_range(0, 31));
    endfunction

    // ---------------- monitor: pops expected read data on each rvld ----------------
    initial begin
        bit en_e, rst_e;
        logic [DW-1:0] exp;
        forever begin
            @(posedge clk);
            en_e = i_clk_en; rst_e = i_rst;
            #2;
            if (!m_ok) continue;
            if (rst_e) begin
                chk("a_rvld_after_rst", {31'd0, o_a_rvld}, '0);
                chk("b_rvld_after_rst", {31'd0, o_b_rvld}, '0);
            end else if (en_e) begin
                chk("a_rvld", {31'd0, o_a_rvld}, {31'd0, exp_a_q.size() != 0});
                if (o_a_rvld && exp_a_q.size() != 0) begin
                    exp = exp_a_q.pop_front();
                    chk("a_rdata", o_a_rdata, exp);
                end
                chk("b_rvld", {31'd0, o_b_rvld}, {31'd0, exp_b_q.size() != 0});
                if (o_b_rvld && exp_b_q.size() != 0) begin
                    exp = exp_b_q.pop_front();
                    chk("b_rdata", o_b_rdata, exp);
                end
            end
            if (!o_a_rvld) chk("a_rdata_idle", o_a_rdata, '0);
            if (!o_b_rvld) chk("b_rdata_idle", o_b_rdata, '0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit r_rst, r_en, r_ar, r_aw, r_br, r_bw, r_bl;
        for (int i = 0; i < (1 << RAM_AW); i++) begin
            ram[i]     = 32'h9E3779B1 * i;
            ref_mem[i] = 32'h9E3779B1 * i;
        end
        ram[16'h10] = 32'hAA; ref_mem[16'h10] = 32'hAA;
        ram[16'h20] = 32'hBB; ref_mem[16'h20] = 32'hBB;

        do_reset();
        idle(1);

        // Simultaneous reads: A first, B the next cycle, data back in grant order
        step(0, 1, 1, 0, 24'h10, '0, 1, 0, 24'h20, '0, 0);
        step(0, 1, 0, 0, '0,     '0, 1, 0, 24'h20, '0, 0);
        idle(2);

        // STDOUT write
        step(0, 1, 1, 1, A_STDOUT, 32'h41, 0, 0, '0, '0, 0);
        idle(3);

        // HALT: A blocked afterwards, B still served, status read via B
        step(0, 1, 1, 1, A_HALT, 32'h1, 0, 0, '0, '0, 0);
        step(0, 1, 1, 0, 24'h0, '0, 1, 0, 24'h0, '0, 0);
        step(0, 1, 1, 0, A_HALT, '0, 0, 0, '0, '0, 0);
        step(0, 1, 1, 0, A_HALT, '0, 1, 0, A_HALT, '0, 0);
        idle(2);

        // Locked B burst with A waiting
        do_reset();
        step(0, 1, 1, 0, 24'h10, '0, 1, 1, 24'h30, 32'h1234, 1);
        step(0, 1, 1, 0, 24'h10, '0, 1, 0, 24'h30, '0, 1);
        step(0, 1, 1, 0, 24'h10, '0, 1, 0, 24'h31, '0, 0);
        step(0, 1, 1, 0, 24'h10, '0, 0, 0, '0, '0, 0);
        idle(2);

        // B starving behind continuous A traffic
        do_reset();
        step(0, 1, 1, 0, 24'h1, '0, 0, 0, '0, '0, 0);
        for (int k = 0; k < 8; k++) step(0, 1, 1, 0, AW'(k), '0, 1, 0, 24'h20, '0, 0);
        step(0, 1, 1, 0, 24'h2, '0, 0, 0, '0, '0, 0);
        idle(2);

        // LOCK then HALT, read in flight, frozen cycle, then reset
        do_reset();
        step(0, 1, 0, 0, '0, '0, 1, 1, 24'h5, 32'h55, 1);
        step(0, 1, 0, 0, '0, '0, 1, 1, A_HALT, 32'h1, 1);
        step(0, 1, 0, 0, '0, '0, 1, 0, 24'h3, '0, 1);
        step(0, 0, 1, 0, 24'h10, '0, 0, 0, '0, '0, 0);
        step(1, 1, 1, 0, 24'h10, '0, 0, 0, '0, '0, 0);
        step(0, 1, 1, 0, 24'h10, '0, 0, 0, '0, '0, 0);
        idle(2);

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            r_en  = ($urandom_range(0, 9) != 0);
            r_ar  = 1'($urandom_range(0, 1));
            r_aw  = 1'($urandom_range(0, 1));
            r_br  = 1'($urandom_range(0, 1));
            r_bw  = 1'($urandom_range(0, 1));
            r_bl  = ($urandom_range(0, 9) < 3);
            step(r_rst, r_en, r_ar, r_aw, rnd_addr(), $urandom(),
                 r_br, r_bw, rnd_addr(), $urandom(), r_bl);
        end
        idle(3);
        chk("a_queue_drained", DW'(exp_a_q.size()), '0);
        chk("b_queue_drained", DW'(exp_b_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
